hdr_payload_steer: RTL and testbench

Downstream stage of the header/payload splitter. Consumes its single Avalon-ST stream, which carries header packets and payload packets marked by a per-beat payload flag and a packet ID. It steers header packets to a shallow header output buffer for the parser and payload packets into a deep payload FIFO, tagging each buffered payload packet with its ID. Input ready is derived only from registered occupancy, which breaks the combinational ready/valid loop through the splitter.

---
 rtl/hdr_payload_steer_pkg.sv | 23 ++
 rtl/hdr_payload_steer_if.sv | 20 ++
 rtl/hdr_payload_steer_sync_fifo.sv | 52 +++++
 rtl/hdr_payload_steer.sv | 103 ++++++++++
 tb/tb_hdr_payload_steer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/hdr_payload_steer_pkg.sv
// Shared types and constants for the header/payload steering stage.
// st_beat_t describes one Avalon-ST beat at the default 64-bit bus width.
package hdr_payload_steer_pkg;

    localparam int HDR_DEPTH     = 2;
    localparam int ST_DATA_WIDTH = 64;

    // Keeps the empty field at least one bit wide on byte-wide buses.
    function automatic int empty_width(input int data_width);
        return (data_width > 8) ? $clog2(data_width / 8) : 1;
    endfunction

    localparam int ST_EMPTY_WIDTH = empty_width(ST_DATA_WIDTH);

    typedef struct packed {
        logic [ST_DATA_WIDTH-1:0]  data;
        logic                      sop;
        logic                      eop;
        logic                      error;
        logic [ST_EMPTY_WIDTH-1:0] empty;
    } st_beat_t;

endpackage

// File: rtl/hdr_payload_steer_if.sv
// Avalon-ST streaming bundle with source and sink views.
interface avalonST
    import hdr_payload_steer_pkg::*;
#(
    parameter int DATA_WIDTH = 64
);
    localparam int EMPTY_WIDTH = empty_width(DATA_WIDTH);

    logic                   valid;
    logic                   ready;
    logic [DATA_WIDTH-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic                   error;
    logic [EMPTY_WIDTH-1:0] empty;

    modport src  (output valid, data, sop, eop, error, empty, input  ready);
    modport sink (input  valid, data, sop, eop, error, empty, output ready);

endinterface

// File: rtl/hdr_payload_steer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only honoured when a pop frees the slot in the same cycle.
    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != (PW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Storage is not reset, so an empty FIFO presents zero instead of stale contents.
    assign pop_data = (cnt != '0) ? mem[rd_ptr] : '0;
    assign count    = cnt;

endmodule

// File: rtl/hdr_payload_steer.sv
// Steers header packets to a 2-deep parser buffer and payload packets to a deep FIFO
// tagged with their packet ID; input ready depends only on registered occupancy.
module hdr_payload_steer
    import hdr_payload_steer_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int PAY_DEPTH  = 64,
    parameter int ID_DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    avalonST.sink                      in,
    input  logic                       i_payload,
    input  logic [31:0]                i_id,
    avalonST.src                       out_hdr,
    avalonST.src                       out_pay,
    output logic [31:0]                o_pay_id,
    output logic [$clog2(PAY_DEPTH):0] o_pay_level
);
    localparam int EW    = empty_width(DATA_WIDTH);
    localparam int BW    = DATA_WIDTH + 3 + EW;
    localparam int HCW   = $clog2(HDR_DEPTH) + 1;
    localparam int PCW   = $clog2(PAY_DEPTH) + 1;
    localparam int ICW   = $clog2(ID_DEPTH) + 1;

    logic [BW-1:0]  in_beat;
    logic [BW-1:0]  hdr_head;
    logic [BW-1:0]  pay_head;
    logic [HCW-1:0] hdr_cnt;
    logic [PCW-1:0] pay_cnt;
    logic [ICW-1:0] id_cnt;
    logic           ready_en;
    logic           accept;
    logic           hdr_push;
    logic           pay_push;
    logic           id_push;
    logic           hdr_pop;
    logic           pay_pop;
    logic           id_pop;
    logic           pay_head_eop;

    // Holds ready low through reset and releases it on the first clean edge.
    always_ff @(posedge clk) begin
        if (reset) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
    end

    assign in.ready = ready_en
                   && (hdr_cnt < HCW'(HDR_DEPTH))
                   && (pay_cnt < PCW'(PAY_DEPTH))
                   && (id_cnt  < ICW'(ID_DEPTH));

    assign in_beat  = {in.data, in.sop, in.eop, in.error, in.empty};
    assign accept   = in.valid && in.ready;
    assign hdr_push = accept && !i_payload;
    assign pay_push = accept && i_payload;
    assign id_push  = pay_push && in.sop;

    assign hdr_pop      = out_hdr.valid && out_hdr.ready;
    assign pay_pop      = out_pay.valid && out_pay.ready;
    assign pay_head_eop = pay_head[EW+1];
    // The ID retires together with the last beat of its packet.
    assign id_pop       = pay_pop && pay_head_eop;

    sync_fifo #(.WIDTH(BW), .DEPTH(HDR_DEPTH)) u_hdr_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (hdr_push),
        .push_data (in_beat),
        .pop       (hdr_pop),
        .pop_data  (hdr_head),
        .count     (hdr_cnt)
    );

    sync_fifo #(.WIDTH(BW), .DEPTH(PAY_DEPTH)) u_pay_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pay_push),
        .push_data (in_beat),
        .pop       (pay_pop),
        .pop_data  (pay_head),
        .count     (pay_cnt)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(ID_DEPTH)) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (id_push),
        .push_data (i_id),
        .pop       (id_pop),
        .pop_data  (o_pay_id),
        .count     (id_cnt)
    );

    assign out_hdr.valid = (hdr_cnt != '0);
    assign {out_hdr.data, out_hdr.sop, out_hdr.eop, out_hdr.error, out_hdr.empty} = hdr_head;

    assign out_pay.valid = (pay_cnt != '0);
    assign {out_pay.data, out_pay.sop, out_pay.eop, out_pay.error, out_pay.empty} = pay_head;

    assign o_pay_level = pay_cnt;

endmodule

// File: tb/tb_hdr_payload_steer.sv
// Randomized self-checking bench for hdr_payload_steer against a queue-based
// reference model of the header buffer, payload FIFO and ID FIFO.
module tb_hdr_payload_steer;
    import hdr_payload_steer_pkg::*;

    localparam int DATA_WIDTH = 64;
    localparam int PAY_DEPTH  = 64;
    localparam int ID_DEPTH   = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_payload;
    logic [31:0] i_id;
    logic [31:0] o_pay_id;
    logic [6:0]  o_pay_level;

    avalonST #(.DATA_WIDTH(DATA_WIDTH)) in_if ();
    avalonST #(.DATA_WIDTH(DATA_WIDTH)) hdr_if ();
    avalonST #(.DATA_WIDTH(DATA_WIDTH)) pay_if ();

    hdr_payload_steer #(
        .DATA_WIDTH (DATA_WIDTH),
        .PAY_DEPTH  (PAY_DEPTH),
        .ID_DEPTH   (ID_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in_if),
        .i_payload   (i_payload),
        .i_id        (i_id),
        .out_hdr     (hdr_if),
        .out_pay     (pay_if),
        .o_pay_id    (o_pay_id),
        .o_pay_level (o_pay_level)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    st_beat_t    hdr_q[$];
    st_beat_t    pay_q[$];
    logic [31:0] id_q[$];
    bit          rdy_en_m = 1'b0;

    st_beat_t    cur;
    bit          cur_pay;
    logic [31:0] cur_id;
    bit          have_beat = 1'b0;
    bit          pkt_pay   = 1'b0;
    int          pkt_left  = 0;
    int          reset_hold = 0;

    int p_valid, p_pay, len_min, len_max, p_hdr_rdy, p_pay_rdy, p_reset;

    bit saw_pay_full = 1'b0;
    bit saw_id_full  = 1'b0;
    bit saw_hdr_full = 1'b0;

    task automatic check_output(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic new_beat();
        if (pkt_left == 0) begin
            pkt_pay  = ($urandom_range(99) < p_pay);
            pkt_left = $urandom_range(len_max, len_min);
            cur.sop  = 1'b1;
        end else begin
            cur.sop  = 1'b0;
        end
        cur.data  = {$urandom, $urandom};
        cur.eop   = (pkt_left == 1);
        cur.error = 1'($urandom_range(1));
        cur.empty = 3'($urandom_range(7));
        cur_pay   = pkt_pay;
        cur_id    = $urandom;
        pkt_left--;
        have_beat = 1'b1;
    endtask

    // One cycle: compare outputs with the model, drive new inputs, advance the model.
    task automatic apply_stimulus();
        bit       exp_ready;
        bit       accept;
        bit       do_reset;
        st_beat_t b;

        exp_ready = rdy_en_m && (hdr_q.size() < HDR_DEPTH) && (pay_q.size() < PAY_DEPTH)
                    && (id_q.size() < ID_DEPTH);
        check_output("in_ready",  128'(in_if.ready),  128'(exp_ready));
        check_output("hdr_valid", 128'(hdr_if.valid), 128'(hdr_q.size() != 0));
        check_output("pay_valid", 128'(pay_if.valid), 128'(pay_q.size() != 0));
        check_output("pay_level", 128'(o_pay_level),  128'(pay_q.size()));
        if (hdr_q.size() != 0)
            check_output("hdr_beat", 128'({hdr_if.data, hdr_if.sop, hdr_if.eop, hdr_if.error, hdr_if.empty}),
                         128'(hdr_q[0]));
        if (pay_q.size() != 0) begin
            check_output("pay_beat", 128'({pay_if.data, pay_if.sop, pay_if.eop, pay_if.error, pay_if.empty}),
                         128'(pay_q[0]));
            if (id_q.size() != 0)
                check_output("pay_id", 128'(o_pay_id), 128'(id_q[0]));
        end
        if (pay_q.size() == PAY_DEPTH) saw_pay_full = 1'b1;
        if (id_q.size() == ID_DEPTH)   saw_id_full  = 1'b1;
        if (hdr_q.size() == HDR_DEPTH) saw_hdr_full = 1'b1;

        if (reset_hold == 0 && $urandom_range(99) < p_reset) reset_hold = $urandom_range(2, 1);
        do_reset = (reset_hold != 0);
        if (reset_hold != 0) reset_hold--;

        if (!have_beat) new_beat();
        in_if.valid  = ($urandom_range(99) < p_valid);
        in_if.data   = cur.data;
        in_if.sop    = cur.sop;
        in_if.eop    = cur.eop;
        in_if.error  = cur.error;
        in_if.empty  = cur.empty;
        i_payload    = cur_pay;
        i_id         = cur_id;
        hdr_if.ready = ($urandom_range(99) < p_hdr_rdy);
        pay_if.ready = ($urandom_range(99) < p_pay_rdy);
        reset        = do_reset;

        if (do_reset) begin
            hdr_q.delete();
            pay_q.delete();
            id_q.delete();
            rdy_en_m  = 1'b0;
            pkt_left  = 0;
            have_beat = 1'b0;
        end else begin
            accept = in_if.valid && exp_ready;
            if (hdr_if.ready && hdr_q.size() != 0) void'(hdr_q.pop_front());
            if (pay_if.ready && pay_q.size() != 0) begin
                b = pay_q.pop_front();
                if (b.eop && id_q.size() != 0) void'(id_q.pop_front());
            end
            if (accept) begin
                if (cur_pay) begin
                    pay_q.push_back(cur);
                    if (cur.sop) id_q.push_back(cur_id);
                end else begin
                    hdr_q.push_back(cur);
                end
                have_beat = 1'b0;
            end
            rdy_en_m = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic run_phase(input int cycles, input int pv, input int pp, input int lmin, input int lmax,
                             input int phr, input int ppr, input int prs);
        p_valid   = pv;
        p_pay     = pp;
        len_min   = lmin;
        len_max   = lmax;
        p_hdr_rdy = phr;
        p_pay_rdy = ppr;
        p_reset   = prs;
        for (int i = 0; i < cycles; i++) apply_stimulus();
    endtask

    initial begin
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        in_if.sop    = 1'b0;
        in_if.eop    = 1'b0;
        in_if.error  = 1'b0;
        in_if.empty  = '0;
        i_payload    = 1'b0;
        i_id         = '0;
        hdr_if.ready = 1'b0;
        pay_if.ready = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_pay_id", 128'(o_pay_id), 128'(0));

        run_phase(800, 80, 50, 1, 6, 70, 70, 0);
        // Long payload packets under output stall fill the payload FIFO before the ID FIFO.
        run_phase(150, 100, 100, 10, 16, 100, 0, 0);
        run_phase(200, 100, 100, 10, 16, 100, 100, 0);
        run_phase(120, 0, 0, 1, 1, 100, 100, 0);
        run_phase(60, 100, 100, 1, 1, 100, 0, 0);
        run_phase(120, 0, 0, 1, 1, 100, 100, 0);
        run_phase(60, 100, 0, 1, 4, 0, 100, 0);
        run_phase(400, 100, 50, 1, 3, 50, 50, 0);
        run_phase(800, 80, 70, 1, 8, 70, 70, 2);

        check_output("cov_pay_full", 128'(saw_pay_full), 128'(1));
        check_output("cov_id_full",  128'(saw_id_full),  128'(1));
        check_output("cov_hdr_full", 128'(saw_hdr_full), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
